lpif_dstrm_capture_fifo: RTL and testbench



---
 rtl/lpif_dstrm_capture_fifo.sv | 145 ++++++++++++++
 tb/tb_lpif_dstrm_capture_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lpif_dstrm_capture_fifo.sv
// Capture FIFO for the LPIF slave downstream channel (no backpressure): buffers valid flits,
// presents them FWFT on ready/valid, tracks link state. Stats counters: LPIF_DSTRM_CAPTURE_STATS_EN.
module lpif_dstrm_capture_fifo #(
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                     clk_wr,
    input  logic                     rst_wr,
    input  logic                     rx_online,
    input  logic [3:0]               dstrm_state,
    input  logic [1:0]               dstrm_protid,
    input  logic [63:0]              dstrm_data,
    input  logic                     dstrm_dvalid,
    input  logic [3:0]               dstrm_crc,
    input  logic                     dstrm_crc_valid,
    input  logic                     dstrm_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_protid,
    output logic [63:0]              out_data,
    output logic [3:0]               out_crc,
    output logic                     out_crc_valid,
    output logic [3:0]               link_state,
    output logic                     state_change,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     clear_sticky,
    output logic [15:0]              flit_count,
    output logic [15:0]              drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE     = (AW+1)'(1);
    localparam logic [AW:0] FULL_COUNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_COUNT = (AW+1)'(AFULL_LEVEL);

    typedef struct packed {
        logic        crc_valid;
        logic [3:0]  crc;
        logic [1:0]  protid;
        logic [63:0] data;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      in_entry;
    entry_t      head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        rx_online_q;
    logic        flush;
    logic        push_req;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;

    // Pointers carry one extra MSB so wr - rd distinguishes full from empty.
    assign count       = wr_ptr - rd_ptr;
    assign fifo_count  = count;
    assign full        = (count == FULL_COUNT);
    assign almost_full = (count >= AFULL_COUNT);
    assign out_valid   = (count != '0);

    assign push_req = rx_online & dstrm_valid & dstrm_dvalid;
    assign pop      = out_valid & out_ready;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign flush    = rx_online_q & ~rx_online;

    assign in_entry = {dstrm_crc_valid, dstrm_crc, dstrm_protid, dstrm_data};
    assign head     = mem[rd_ptr[AW-1:0]];

    // Head fields are masked while empty so stale or uninitialised entries never leak out.
    assign out_data      = out_valid ? head.data      : '0;
    assign out_protid    = out_valid ? head.protid    : '0;
    assign out_crc       = out_valid ? head.crc       : '0;
    assign out_crc_valid = out_valid ? head.crc_valid : 1'b0;

    // NOTE: storage array has no reset; out_valid gates every read, so its contents never matter.
    always_ff @(posedge clk_wr) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_entry;
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rx_online_q <= 1'b0;
        end else begin
            rx_online_q <= rx_online;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // A drop in the same cycle as clear_sticky keeps the flag set.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr)            overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (clear_sticky) overflow <= 1'b0;
    end

    // Link tracking ignores rx_online; it follows every valid beat on the channel.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            link_state   <= 4'h0;
            state_change <= 1'b0;
        end else if (dstrm_valid) begin
            link_state   <= dstrm_state;
            state_change <= (dstrm_state != link_state);
        end else begin
            state_change <= 1'b0;
        end
    end

`ifdef LPIF_DSTRM_CAPTURE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // An event coinciding with clear_sticky restarts the counter at one.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            flit_count <= 16'h0;
            drop_count <= 16'h0;
        end else begin
            if (push)              flit_count <= clear_sticky ? 16'd1 : sat_inc(flit_count);
            else if (clear_sticky) flit_count <= 16'h0;
            if (drop)              drop_count <= clear_sticky ? 16'd1 : sat_inc(drop_count);
            else if (clear_sticky) drop_count <= 16'h0;
        end
    end
`else
    assign flit_count = 16'h0;
    assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_lpif_dstrm_capture_fifo.sv
// Directed self-checking bench for lpif_dstrm_capture_fifo (DEPTH=8, AFULL_LEVEL=6).
module tb_lpif_dstrm_capture_fifo;
`ifdef LPIF_DSTRM_CAPTURE_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk_wr = 1'b0;
    logic        rst_wr = 1'b0;
    logic        rx_online = 1'b0;
    logic [3:0]  dstrm_state = 4'h0;
    logic [1:0]  dstrm_protid = 2'h0;
    logic [63:0] dstrm_data = 64'h0;
    logic        dstrm_dvalid = 1'b0;
    logic [3:0]  dstrm_crc = 4'h0;
    logic        dstrm_crc_valid = 1'b0;
    logic        dstrm_valid = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_protid;
    logic [63:0] out_data;
    logic [3:0]  out_crc;
    logic        out_crc_valid;
    logic [3:0]  link_state;
    logic        state_change;
    logic [3:0]  fifo_count;
    logic        almost_full;
    logic        overflow;
    logic        clear_sticky = 1'b0;
    logic [15:0] flit_count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int pulses;

    lpif_dstrm_capture_fifo #(.DEPTH(8), .AFULL_LEVEL(6)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .rx_online(rx_online),
        .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
        .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
        .dstrm_valid(dstrm_valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_protid(out_protid), .out_data(out_data), .out_crc(out_crc),
        .out_crc_valid(out_crc_valid), .link_state(link_state), .state_change(state_change),
        .fifo_count(fifo_count), .almost_full(almost_full), .overflow(overflow),
        .clear_sticky(clear_sticky), .flit_count(flit_count), .drop_count(drop_count)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic drive(input logic v, input logic dv, input logic [3:0] st, input logic [63:0] d);
        dstrm_valid     = v;
        dstrm_dvalid    = dv;
        dstrm_state     = st;
        dstrm_data      = d;
        dstrm_protid    = d[1:0];
        dstrm_crc       = ~d[3:0];
        dstrm_crc_valid = dv;
    endtask

    initial begin
        // Reset state
        #2 rst_wr = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_link_state", 64'(link_state), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_state_change", 64'(state_change), 64'd0);
        check("rst_flit_count", 64'(flit_count), 64'd0);
        @(negedge clk_wr);
        rst_wr    = 1'b0;
        rx_online = 1'b1;

        // Three pushes, then drain in order
        drive(1'b1, 1'b1, 4'h0, 64'h1);
        step();
        check("t1_latency_valid", 64'(out_valid), 64'd1);
        check("t1_latency_count", 64'(fifo_count), 64'd1);
        drive(1'b1, 1'b1, 4'h0, 64'h2);
        step();
        drive(1'b1, 1'b1, 4'h0, 64'h3);
        step();
        drive(1'b0, 1'b0, 4'h0, 64'h0);
        check("t1_count3", 64'(fifo_count), 64'd3);
        check("t1_head", out_data, 64'h1);
        check("t1_head_protid", 64'(out_protid), 64'd1);
        check("t1_head_crc", 64'(out_crc), 64'hE);
        check("t1_head_crc_valid", 64'(out_crc_valid), 64'd1);
        step();
        check("t1_hold_head", out_data, 64'h1);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check("t1_drain", out_data, 64'(i));
            step();
        end
        check("t1_empty_valid", 64'(out_valid), 64'd0);
        check("t1_empty_count", 64'(fifo_count), 64'd0);
        out_ready = 1'b0;

        // Ten pushes into eight entries: two drops
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 4'h0, 64'(10 + i));
            step();
            if (i == 4) check("t2_afull_below", 64'(almost_full), 64'd0);
            if (i == 5) check("t2_afull_at", 64'(almost_full), 64'd1);
            if (i == 7) check("t2_no_overflow_yet", 64'(overflow), 64'd0);
        end
        drive(1'b0, 1'b0, 4'h0, 64'h0);
        check("t2_count_full", 64'(fifo_count), 64'd8);
        check("t2_overflow", 64'(overflow), 64'd1);
        check("t2_drop_count", 64'(drop_count), STATS_EN ? 64'd2 : 64'd0);
        check("t2_flit_count", 64'(flit_count), STATS_EN ? 64'd11 : 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_drain", out_data, 64'(10 + i));
            step();
        end
        check("t2_drained", 64'(fifo_count), 64'd0);
        check("t2_overflow_sticky", 64'(overflow), 64'd1);
        out_ready    = 1'b0;
        clear_sticky = 1'b1;
        step();
        clear_sticky = 1'b0;
        check("t2_clear_overflow", 64'(overflow), 64'd0);
        check("t2_clear_drop", 64'(drop_count), 64'd0);
        check("t2_clear_flit", 64'(flit_count), 64'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 4'h0, 64'(100 + i));
            step();
        end
        drive(1'b1, 1'b1, 4'h0, 64'd200);
        out_ready = 1'b1;
        step();
        drive(1'b0, 1'b0, 4'h0, 64'h0);
        check("t3_count_kept", 64'(fifo_count), 64'd8);
        check("t3_no_overflow", 64'(overflow), 64'd0);
        check("t3_flit_count", 64'(flit_count), STATS_EN ? 64'd9 : 64'd0);
        for (int i = 1; i < 8; i++) begin
            check("t3_drain", out_data, 64'(100 + i));
            step();
        end
        check("t3_last_out", out_data, 64'd200);
        step();
        check("t3_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Link tracking: 0,0,(ignored 9),3,3,5
        pulses = 0;
        drive(1'b1, 1'b0, 4'h0, 64'h0); step(); pulses += int'(state_change);
        drive(1'b1, 1'b0, 4'h0, 64'h0); step(); pulses += int'(state_change);
        drive(1'b0, 1'b0, 4'h9, 64'h0); step(); pulses += int'(state_change);
        check("t4_ignored_state", 64'(link_state), 64'd0);
        drive(1'b1, 1'b0, 4'h3, 64'h0); step(); pulses += int'(state_change);
        check("t4_pulse_3", 64'(state_change), 64'd1);
        drive(1'b1, 1'b0, 4'h3, 64'h0); step(); pulses += int'(state_change);
        check("t4_pulse_width", 64'(state_change), 64'd0);
        drive(1'b1, 1'b0, 4'h5, 64'h0); step(); pulses += int'(state_change);
        drive(1'b0, 1'b0, 4'h5, 64'h0); step(); pulses += int'(state_change);
        check("t4_pulse_count", 64'(pulses), 64'd2);
        check("t4_link_state", 64'(link_state), 64'd5);
        check("t4_no_fifo_push", 64'(fifo_count), 64'd0);

        // Flush on rx_online falling edge
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 4'h5, 64'(300 + i));
            step();
        end
        drive(1'b0, 1'b0, 4'h5, 64'h0);
        check("t5_count4", 64'(fifo_count), 64'd4);
        rx_online = 1'b0;
        step();
        check("t5_flush_count", 64'(fifo_count), 64'd0);
        check("t5_flush_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 1'b1, 4'h5, 64'h55);
        step();
        step();
        check("t5_blocked", 64'(fifo_count), 64'd0);
        rx_online = 1'b1;
        drive(1'b1, 1'b1, 4'h5, 64'h77);
        step();
        drive(1'b0, 1'b0, 4'h5, 64'h0);
        check("t5_resume_count", 64'(fifo_count), 64'd1);
        check("t5_resume_data", out_data, 64'h77);
        check("t5_flit_count", 64'(flit_count), STATS_EN ? 64'd14 : 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5_drained", 64'(fifo_count), 64'd0);

        // Async reset mid-burst
        drive(1'b1, 1'b1, 4'h6, 64'h11);
        step();
        drive(1'b1, 1'b1, 4'h6, 64'h22);
        step();
        check("t6_pre_link", 64'(link_state), 64'd6);
        check("t6_pre_count", 64'(fifo_count), 64'd2);
        #2 rst_wr = 1'b1;
        #1;
        check("t6_async_valid", 64'(out_valid), 64'd0);
        check("t6_async_count", 64'(fifo_count), 64'd0);
        check("t6_async_data", out_data, 64'd0);
        check("t6_async_link", 64'(link_state), 64'd0);
        check("t6_async_flit", 64'(flit_count), 64'd0);
        #2 rst_wr = 1'b0;
        drive(1'b1, 1'b1, 4'h6, 64'hA5);
        step();
        drive(1'b0, 1'b0, 4'h6, 64'h0);
        check("t6_first_push_valid", 64'(out_valid), 64'd1);
        check("t6_first_push_data", out_data, 64'hA5);
        check("t6_flit_after_reset", 64'(flit_count), STATS_EN ? 64'd1 : 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
